relock_output_sum: RTL and testbench
====================================

// Module: relock_output_sum
// PURPOSE
//  Output stage directly downstream of the relock sweep generator. Adds the loop-filter output and the relock
//  sweep, clamps the sum to the programmed output window, and drives the DAC word. It also produces the
//  debounced railed[1:0] flags that feed back to the relock block's railed input. The output is frozen while
//  the hold input is asserted.
// PARAMETERS
//  FILTER_SIZE      18  width of filter_in (signed, output-LSB units)
//  SIGNAL_OUT_SIZE  16  relock sweep size; relock_in is SIGNAL_OUT_SIZE+2 bits (signed, output-LSB units)
//  OUT_SIZE         16  width of dac_out, minval_in, maxval_in
//  RAIL_CNT_BITS     8  width of the rail debounce counter and rail_delay_in
// PORTS
//  clk_in           in   1                  system clock; all logic on rising edge
//  rst_n_in         in   1                  synchronous, active-low reset
//  on_in            in   1                  relock enable; 0 forces the relock contribution to zero
//  filter_in        in   FILTER_SIZE        signed loop-filter output
//  filter_valid_in  in   1                  filter_in sample strobe (1-cycle pulse)
//  relock_in        in   SIGNAL_OUT_SIZE+2  signed relock sweep
//  minval_in        in   OUT_SIZE           signed lower output limit
//  maxval_in        in   OUT_SIZE           signed upper output limit
//  rail_delay_in    in   RAIL_CNT_BITS      extra out-of-window samples required before a railed flag asserts
//  hold_in          in   1                  freeze dac_out (from relock hold_out)
//  dac_out          out  OUT_SIZE           signed clamped output word
//  dac_valid_out    out  1                  dac_out update strobe
//  railed_out       out  2                  [1]=railed high, [0]=railed low
// BEHAVIOUR
//  - Reset (rst_n_in=0 at clock edge): dac_out=0, dac_valid_out=0, railed_out=2'b00, debounce counters=0,
//    pipeline valids=0. A reset mid-pipeline discards the in-flight samples.
//  - S1, on filter_valid_in: sum = sext(filter_in) + (on_in ? sext(relock_in) : 0). The sum width is
//    max(FILTER_SIZE, SIGNAL_OUT_SIZE+2)+1, so the addition never overflows. relock_in is sampled on the
//    same cycle as filter_in.
//  - S2: compare the sum against maxval_in and minval_in (sign-extended). hi = sum>maxval, lo = sum<minval.
//    clamp = hi ? maxval : lo ? minval : sum[OUT_SIZE-1:0].
//    If minval_in>maxval_in, the hi test takes priority and the output is maxval_in.
//  - dac_out takes clamp unless hold_in=1 in the S2 cycle; in that case dac_out keeps its old value.
//    dac_valid_out pulses in both cases.
//  - Latency: filter_valid_in at cycle N -> dac_valid_out and dac_out at N+2. Throughput is 1 sample/cycle.
//  - Rail debounce, one counter per side, updated only on S2-valid cycles:
//      * side out of window: the counter increments and saturates at all-ones.
//      * side in window: the counter clears, and the flag clears on the same edge.
//      * railed_out[side] sets on the edge where counter==rail_delay_in while still out of window.
//      * rail_delay_in=0: the flag asserts on the first out-of-window sample (same edge as dac_valid_out).
//      * hi and lo cannot both be true unless min>max. When both are true, only the hi counter runs.
//  - railed_out is held through hold_in. A change of minval_in/maxval_in takes effect on the next S2 sample.
// CONFIGURATION
//  RELOCK_OUT_SLEW_EN defined:
//    - Adds input slew_in [OUT_SIZE-1:0] (unsigned) and a stage S3.
//    - On each valid sample, dac_out moves toward clamp by at most slew_in.
//    - slew_in=0 means no slew limit.
//    - Latency becomes 3 cycles. Hold and the railed flags use the S2 (unslewed) values.
//  RELOCK_OUT_SLEW_EN undefined: the port is absent and the latency is 2 cycles.
// TESTING
//  1. filter_in=1000, relock_in=-200, on_in=1, limits +-32767, pulse valid -> dac_out=800 two cycles later;
//     on_in=0 -> 1000.
//  2. maxval=5000, filter_in=6000 on every cycle, rail_delay_in=3 -> dac_out=5000 and railed_out=2'b10
//     on the 4th valid output; one in-window sample clears it.
//  3. minval=-5000, filter_in=-20000, rail_delay_in=0 -> dac_out=-5000, railed_out[0]=1 with the first output.
//  4. filter_in=131071 + relock_in=131071 (extreme widths) -> no wrap; dac_out=maxval, railed_out[1] set.
//  5. hold_in=1 while filter_in steps 100->900 -> dac_out stays 100, dac_valid_out still pulses.
//     Release hold -> 900.
//  6. Assert rst_n_in=0 one cycle after a valid sample -> no dac_valid_out follows; all outputs 0.
//     (With RELOCK_OUT_SLEW_EN, slew_in=50, step 0->500 -> 10 samples of +50.)

Source files
------------

// File: rtl/relock_output_sum_if.sv
// ============================================================================
//  Module      : relock_output_sum_if
//  Description : Sample/limit/DAC bundle between the relock datapath and the
//                output-sum stage. RELOCK_OUT_SLEW_EN adds slew_in.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface relock_output_sum_if #(
    parameter int FILTER_SIZE     = 18,
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int OUT_SIZE        = 16,
    parameter int RAIL_CNT_BITS   = 8
);
    logic                         on_in;
    logic [FILTER_SIZE-1:0]       filter_in;
    logic                         filter_valid_in;
    logic [SIGNAL_OUT_SIZE+1:0]   relock_in;
    logic [OUT_SIZE-1:0]          minval_in;
    logic [OUT_SIZE-1:0]          maxval_in;
    logic [RAIL_CNT_BITS-1:0]     rail_delay_in;
    logic                         hold_in;
    logic [OUT_SIZE-1:0]          dac_out;
    logic                         dac_valid_out;
    logic [1:0]                   railed_out;
`ifdef RELOCK_OUT_SLEW_EN
    logic [OUT_SIZE-1:0]          slew_in;

    modport master (
        output on_in, filter_in, filter_valid_in, relock_in, minval_in, maxval_in,
               rail_delay_in, hold_in, slew_in,
        input  dac_out, dac_valid_out, railed_out
    );
    modport slave (
        input  on_in, filter_in, filter_valid_in, relock_in, minval_in, maxval_in,
               rail_delay_in, hold_in, slew_in,
        output dac_out, dac_valid_out, railed_out
    );
`else
    modport master (
        output on_in, filter_in, filter_valid_in, relock_in, minval_in, maxval_in,
               rail_delay_in, hold_in,
        input  dac_out, dac_valid_out, railed_out
    );
    modport slave (
        input  on_in, filter_in, filter_valid_in, relock_in, minval_in, maxval_in,
               rail_delay_in, hold_in,
        output dac_out, dac_valid_out, railed_out
    );
`endif
endinterface

`default_nettype wire

// File: rtl/relock_output_sum.sv
// ============================================================================
//  Module      : relock_output_sum
//  Description : Sums loop filter and relock sweep, clamps to the output window,
//                drives the DAC word and debounced railed flags.
//                Optional macro RELOCK_OUT_SLEW_EN adds a slew-limited S3 stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module relock_output_sum #(
    parameter int FILTER_SIZE     = 18,
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int OUT_SIZE        = 16,
    parameter int RAIL_CNT_BITS   = 8
) (
    input  wire logic             clk_in,
    input  wire logic             rst_n_in,
    relock_output_sum_if.slave    bus
);

    localparam int c_relock_w = SIGNAL_OUT_SIZE + 2;
    localparam int c_sum_w    = ((FILTER_SIZE > c_relock_w) ? FILTER_SIZE : c_relock_w) + 1;
    localparam logic [RAIL_CNT_BITS-1:0] c_cnt_one = 1;

    // ---------------- S1: sum ----------------
    logic signed [c_sum_w-1:0] w_filter_ext;
    logic signed [c_sum_w-1:0] w_relock_ext;
    logic signed [c_sum_w-1:0] w_relock_term;
    logic signed [c_sum_w-1:0] r_s1_sum;
    logic                      r_s1_valid;

    assign w_filter_ext  = {{(c_sum_w-FILTER_SIZE){bus.filter_in[FILTER_SIZE-1]}}, bus.filter_in};
    assign w_relock_ext  = {{(c_sum_w-c_relock_w){bus.relock_in[c_relock_w-1]}}, bus.relock_in};
    assign w_relock_term = bus.on_in ? w_relock_ext : '0;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
        end else begin
            r_s1_valid <= bus.filter_valid_in;
            if (bus.filter_valid_in) begin
                r_s1_sum <= w_filter_ext + w_relock_term;
            end
        end
    end

    // ---------------- S2: window compare and clamp ----------------
    logic signed [c_sum_w-1:0] w_max_ext;
    logic signed [c_sum_w-1:0] w_min_ext;
    logic                      w_hi;
    logic                      w_lo;
    logic                      w_lo_run;
    logic [OUT_SIZE-1:0]       w_clamp;

    assign w_max_ext = {{(c_sum_w-OUT_SIZE){bus.maxval_in[OUT_SIZE-1]}}, bus.maxval_in};
    assign w_min_ext = {{(c_sum_w-OUT_SIZE){bus.minval_in[OUT_SIZE-1]}}, bus.minval_in};
    assign w_hi      = (r_s1_sum > w_max_ext);
    assign w_lo      = (r_s1_sum < w_min_ext);
    // An inverted window (min > max) counts only as railed high.
    assign w_lo_run  = w_lo & ~w_hi;
    assign w_clamp   = w_hi ? bus.maxval_in :
                       w_lo ? bus.minval_in : r_s1_sum[OUT_SIZE-1:0];

    // ---------------- Rail debounce ----------------
    logic [RAIL_CNT_BITS-1:0] r_cnt_hi;
    logic [RAIL_CNT_BITS-1:0] r_cnt_lo;
    logic [RAIL_CNT_BITS-1:0] w_cnt_hi_inc;
    logic [RAIL_CNT_BITS-1:0] w_cnt_lo_inc;
    logic [1:0]               r_railed;

    assign w_cnt_hi_inc = (&r_cnt_hi) ? r_cnt_hi : r_cnt_hi + c_cnt_one;
    assign w_cnt_lo_inc = (&r_cnt_lo) ? r_cnt_lo : r_cnt_lo + c_cnt_one;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_cnt_hi <= '0;
            r_cnt_lo <= '0;
            r_railed <= 2'b00;
        end else if (r_s1_valid) begin
            if (w_hi) begin
                r_cnt_hi <= w_cnt_hi_inc;
                if (r_cnt_hi == bus.rail_delay_in) begin
                    r_railed[1] <= 1'b1;
                end
            end else begin
                r_cnt_hi    <= '0;
                r_railed[1] <= 1'b0;
            end
            if (w_lo_run) begin
                r_cnt_lo <= w_cnt_lo_inc;
                if (r_cnt_lo == bus.rail_delay_in) begin
                    r_railed[0] <= 1'b1;
                end
            end else begin
                r_cnt_lo    <= '0;
                r_railed[0] <= 1'b0;
            end
        end
    end

    assign bus.railed_out = r_railed;

    // ---------------- Output register(s) ----------------
    logic [OUT_SIZE-1:0] r_dac;
    logic                r_dac_valid;

`ifdef RELOCK_OUT_SLEW_EN
    logic [OUT_SIZE-1:0]        r_target;
    logic                       r_s2_valid;
    logic                       r_s2_hold;
    logic signed [OUT_SIZE:0]   w_diff;
    logic signed [OUT_SIZE:0]   w_slew_ext;
    logic signed [OUT_SIZE:0]   w_up;
    logic signed [OUT_SIZE:0]   w_dn;
    logic [OUT_SIZE-1:0]        w_slewed;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_s2_valid <= 1'b0;
            r_s2_hold  <= 1'b0;
            r_target   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_hold <= bus.hold_in;
                if (!bus.hold_in) begin
                    r_target <= w_clamp;
                end
            end
        end
    end

    assign w_diff     = {r_target[OUT_SIZE-1], r_target} - {r_dac[OUT_SIZE-1], r_dac};
    assign w_slew_ext = {1'b0, bus.slew_in};
    assign w_up       = {r_dac[OUT_SIZE-1], r_dac} + w_slew_ext;
    assign w_dn       = {r_dac[OUT_SIZE-1], r_dac} - w_slew_ext;

    // A zero slew limit passes the target straight through.
    always_comb begin
        w_slewed = r_target;
        if (bus.slew_in != '0) begin
            if (w_diff > w_slew_ext) begin
                w_slewed = w_up[OUT_SIZE-1:0];
            end else if (w_diff < -w_slew_ext) begin
                w_slewed = w_dn[OUT_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_dac       <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            r_dac_valid <= r_s2_valid;
            if (r_s2_valid && !r_s2_hold) begin
                r_dac <= w_slewed;
            end
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_dac       <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            r_dac_valid <= r_s1_valid;
            if (r_s1_valid && !bus.hold_in) begin
                r_dac <= w_clamp;
            end
        end
    end
`endif

    assign bus.dac_out       = r_dac;
    assign bus.dac_valid_out = r_dac_valid;

endmodule

`default_nettype wire

// File: tb/tb_relock_output_sum.sv
// ============================================================================
//  Module      : tb_relock_output_sum
//  Description : Scoreboard bench for relock_output_sum (default build).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_relock_output_sum;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    relock_output_sum_if bus ();

    relock_output_sum dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    typedef struct {
        int    dac;
        int    railed;
        int    cyc;
        string name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per dac_valid_out pulse.
    always begin : monitor
        exp_t e;
        @(posedge clk_in);
        #1;
        if (bus.dac_valid_out === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got dac_valid_out=1 with dac_out=%0d, expected no output",
                         $signed(bus.dac_out));
            end else begin
                e = q.pop_front();
                check({e.name, "_dac"},     int'($signed(bus.dac_out)), e.dac);
                check({e.name, "_railed"},  int'(bus.railed_out),       e.railed);
                check({e.name, "_latency"}, cyc - e.cyc,                2);
            end
        end
    end

    task automatic send(input string name, input int f, input int r, input bit on, input bit hold,
                        input int exp_dac, input int exp_rail);
        exp_t e;
        bus.filter_in       = f[17:0];
        bus.relock_in       = r[17:0];
        bus.on_in           = on;
        bus.hold_in         = hold;
        bus.filter_valid_in = 1'b1;
        e.dac    = exp_dac;
        e.railed = exp_rail;
        e.cyc    = cyc;
        e.name   = name;
        q.push_back(e);
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        bus.filter_valid_in = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic limits(input int mn, input int mx, input int dly);
        bus.minval_in     = mn[15:0];
        bus.maxval_in     = mx[15:0];
        bus.rail_delay_in = dly[7:0];
    endtask

    initial begin
        bus.on_in           = 1'b0;
        bus.filter_in       = '0;
        bus.filter_valid_in = 1'b0;
        bus.relock_in       = '0;
        bus.hold_in         = 1'b0;
`ifdef RELOCK_OUT_SLEW_EN
        bus.slew_in         = '0;
`endif
        limits(-32767, 32767, 0);
        repeat (3) @(negedge clk_in);
        check("reset_dac",    int'(bus.dac_out),       0);
        check("reset_valid",  int'(bus.dac_valid_out), 0);
        check("reset_railed", int'(bus.railed_out),    0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Basic sum and relock enable
        send("sum_on",  1000, -200, 1'b1, 1'b0, 800, 0);   idle(3);
        send("sum_off", 1000, -200, 1'b0, 1'b0, 1000, 0);  idle(3);
        send("sum_neg", -300, -700, 1'b1, 1'b0, -1000, 0); idle(3);

        // High rail with debounce delay 3, streamed back to back
        limits(-32767, 5000, 3);
        send("hi_d3_1", 6000, 0, 1'b0, 1'b0, 5000, 0);
        send("hi_d3_2", 6000, 0, 1'b0, 1'b0, 5000, 0);
        send("hi_d3_3", 6000, 0, 1'b0, 1'b0, 5000, 0);
        send("hi_d3_4", 6000, 0, 1'b0, 1'b0, 5000, 2);
        send("hi_d3_5", 6000, 0, 1'b0, 1'b0, 5000, 2);
        send("hi_clear", 100, 0, 1'b0, 1'b0, 100, 0);
        idle(3);

        // Low rail, zero delay
        limits(-5000, 32767, 0);
        send("lo_d0_1", -20000, 0, 1'b0, 1'b0, -5000, 1); idle(3);
        send("lo_d0_2", -20000, 0, 1'b0, 1'b0, -5000, 1); idle(3);
        send("lo_clear", 0,     0, 1'b0, 1'b0, 0,     0); idle(3);

        // Extreme widths must not wrap
        limits(-30000, 30000, 0);
        send("ext_pos", 131071,  131071,  1'b1, 1'b0, 30000,  2); idle(3);
        send("ext_neg", -131072, -131072, 1'b1, 1'b0, -30000, 1); idle(3);

        // Exactly on the limits is in window
        limits(-5000, 5000, 0);
        send("edge_max", 5000,  0, 1'b0, 1'b0, 5000,  0); idle(3);
        send("edge_min", -5000, 0, 1'b0, 1'b0, -5000, 0); idle(3);

        // Inverted window: hi wins
        limits(100, -100, 0);
        send("inverted", 0, 0, 1'b0, 1'b0, -100, 2); idle(3);

        // Hold freezes dac_out but still strobes valid
        limits(-32767, 32767, 0);
        send("hold_pre",  100, 0, 1'b0, 1'b0, 100, 0); idle(3);
        send("hold_a",    500, 0, 1'b0, 1'b1, 100, 0); idle(3);
        send("hold_b",    900, 0, 1'b0, 1'b1, 100, 0); idle(3);
        send("hold_rel",  900, 0, 1'b0, 1'b0, 900, 0); idle(3);

        // Reset one cycle after a valid sample drops it
        bus.filter_in       = 18'd7;
        bus.filter_valid_in = 1'b1;
        @(negedge clk_in);
        bus.filter_valid_in = 1'b0;
        rst_n_in            = 1'b0;
        @(negedge clk_in);
        check("midrst_dac",    int'(bus.dac_out),       0);
        check("midrst_valid",  int'(bus.dac_valid_out), 0);
        check("midrst_railed", int'(bus.railed_out),    0);
        rst_n_in = 1'b1;
        idle(4);
        send("post_rst", 42, 0, 1'b0, 1'b0, 42, 0); idle(3);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk_in);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d outstanding outputs, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
